// File: rtl/board_pkg.sv
// board_pkg: direction codes, engine FSM states and cell indexing shared by the 2048 engine
package board_pkg;
  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;
  typedef enum logic [2:0] {IDLE, SLIDE, SPAWN, CHECK, HOLD} state_t;
  function automatic int cell_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/board_line_slide.sv
// board_line_slide: compresses one line toward its head, merging each equal pair at most once
module board_line_slide #(
  parameter int N       = 4,
  parameter int TILE_W  = 4,
  parameter int SCORE_W = 20
) (
  input  logic [N*TILE_W-1:0] line_in,
  output logic [N*TILE_W-1:0] line_out,
  output logic                changed,
  output logic [SCORE_W-1:0]  score_delta
);
  logic [TILE_W-1:0]   v;
  logic [TILE_W-1:0]   prev;
  logic                have;
  logic [N*TILE_W-1:0] ext;
  logic [SCORE_W:0]    sum;
  int                  o;
  int                  e1;
  // single pass: prev holds the last tile seen that may still merge with the next one
  always_comb begin
    line_out = '0;
    score_delta = '0;
    v = '0;
    prev = '0;
    have = 1'b0;
    ext = '0;
    sum = '0;
    o = 0;
    e1 = 0;
    for (int i = 0; i < N; i++) begin
      v = line_in[i*TILE_W +: TILE_W];
      if (v != '0) begin
        if (have && prev == v) begin
          ext = '0;
          ext[TILE_W-1:0] = (v == '1) ? v : v + TILE_W'(1);
          line_out = line_out | (ext << (o * TILE_W));
          o = o + 1;
          have = 1'b0;
          e1 = int'(v) + 1;
          sum = {1'b0, score_delta} + ((e1 >= SCORE_W) ? {1'b0, {SCORE_W{1'b1}}} : ((SCORE_W+1)'(1) << e1));
          score_delta = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end else begin
          if (have) begin
            ext = '0;
            ext[TILE_W-1:0] = prev;
            line_out = line_out | (ext << (o * TILE_W));
            o = o + 1;
          end
          prev = v;
          have = 1'b1;
        end
      end
    end
    if (have) begin
      ext = '0;
      ext[TILE_W-1:0] = prev;
      line_out = line_out | (ext << (o * TILE_W));
    end
  end
  assign changed = line_out != line_in;
endmodule

// File: rtl/board_engine_nxn.sv
// board_engine_nxn: NxN 2048 engine, one line per clock; BOARD_SPAWN_FOUR_EN adds rand_hi for exponent-2 spawns
module board_engine_nxn import board_pkg::*; #(
  parameter int N        = 4,
  parameter int TILE_W   = 4,
  parameter int WIN_EXP  = 11,
  parameter int TURN_W   = 14,
  parameter int SCORE_W  = 20,
  parameter int HOLD_CYC = 1200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move_valid,
  input  logic [1:0]                move_dir,
  output logic                      move_ready,
  input  logic [$clog2(N*N)-1:0]    rand_in,
`ifdef BOARD_SPAWN_FOUR_EN
  input  logic [2:0]                rand_hi,
`endif
  output logic [N*N*TILE_W-1:0]     board_out,
  output logic [TURN_W-1:0]         turns,
  output logic [SCORE_W-1:0]        score,
  output logic                      won,
  output logic                      lost
);
  localparam int CELLS  = N * N;
  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  state_t                  state_q, state_d;
  logic [1:0]              dir_q, dir_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    changed_q, changed_d;
  logic [CELLS*TILE_W-1:0] board_q, board_d;
  logic [TURN_W-1:0]       turns_q, turns_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic                    won_q, won_d, lost_q, lost_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [N*TILE_W-1:0]     line_in, line_out;
  logic                    line_changed;
  logic [SCORE_W-1:0]      line_score;
  logic [SCORE_W:0]        score_sum;
  logic [TILE_W-1:0]       spawn_val;
  logic                    found, full, pair;
  function automatic int line_cell(input logic [1:0] d, input int i, input int j);
    int p;
    p = (d == DIR_RIGHT || d == DIR_DOWN) ? N - 1 - j : j;
    return (d == DIR_LEFT || d == DIR_RIGHT) ? cell_idx(i, p, N) : cell_idx(p, i, N);
  endfunction
  function automatic logic [TILE_W-1:0] cell_at(input logic [CELLS*TILE_W-1:0] b, input int r, input int c);
    return b[cell_idx(r, c, N)*TILE_W +: TILE_W];
  endfunction
`ifdef BOARD_SPAWN_FOUR_EN
  assign spawn_val = (rand_hi == 3'd0) ? TILE_W'(2) : TILE_W'(1);
`else
  assign spawn_val = TILE_W'(1);
`endif
  board_line_slide #(.N(N), .TILE_W(TILE_W), .SCORE_W(SCORE_W)) u_slide (
    .line_in     (line_in),
    .line_out    (line_out),
    .changed     (line_changed),
    .score_delta (line_score)
  );
  // gather the current line, head first, from the board
  always_comb begin
    line_in = '0;
    for (int j = 0; j < N; j++)
      line_in[j*TILE_W +: TILE_W] = board_q[line_cell(dir_q, int'(idx_q), j)*TILE_W +: TILE_W];
  end
  // next-state: accept, slide line by line, spawn, evaluate win/loss, hold then clear
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    idx_d = idx_q;
    changed_d = changed_q;
    board_d = board_q;
    turns_d = turns_q;
    score_d = score_q;
    won_d = won_q;
    lost_d = lost_q;
    hold_d = hold_q;
    score_sum = '0;
    found = 1'b0;
    full = 1'b1;
    pair = 1'b0;
    case (state_q)
      IDLE: if (move_valid) begin
        dir_d = move_dir;
        changed_d = 1'b0;
        idx_d = '0;
        state_d = SLIDE;
      end
      SLIDE: begin
        for (int j = 0; j < N; j++)
          board_d[line_cell(dir_q, int'(idx_q), j)*TILE_W +: TILE_W] = line_out[j*TILE_W +: TILE_W];
        changed_d = changed_q | line_changed;
        score_sum = {1'b0, score_q} + {1'b0, line_score};
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        idx_d = idx_q + IDX_W'(1);
        state_d = (int'(idx_q) == N - 1) ? SPAWN : SLIDE;
      end
      SPAWN: begin
        if (changed_q) begin
          for (int j = 0; j < CELLS; j++)
            if (!found && board_q[((int'(rand_in) + j) % CELLS)*TILE_W +: TILE_W] == '0) begin
              board_d[((int'(rand_in) + j) % CELLS)*TILE_W +: TILE_W] = spawn_val;
              found = 1'b1;
            end
          turns_d = turns_q + TURN_W'(1);
        end
        state_d = CHECK;
      end
      CHECK: begin
        won_d = 1'b0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            if (int'(cell_at(board_q, r, c)) >= WIN_EXP) won_d = 1'b1;
            if (cell_at(board_q, r, c) == '0) full = 1'b0;
          end
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N - 1; c++)
            if (cell_at(board_q, r, c) == cell_at(board_q, r, c + 1)) pair = 1'b1;
        for (int r = 0; r < N - 1; r++)
          for (int c = 0; c < N; c++)
            if (cell_at(board_q, r, c) == cell_at(board_q, r + 1, c)) pair = 1'b1;
        lost_d = !won_d && full && !pair;
        hold_d = '0;
        state_d = (won_d || lost_d) ? HOLD : IDLE;
      end
      HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          board_d = '0;
          turns_d = '0;
          score_d = '0;
          won_d = 1'b0;
          lost_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q <= DIR_LEFT;
      idx_q <= '0;
      changed_q <= 1'b0;
      board_q <= '0;
      turns_q <= '0;
      score_q <= '0;
      won_q <= 1'b0;
      lost_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      idx_q <= idx_d;
      changed_q <= changed_d;
      board_q <= board_d;
      turns_q <= turns_d;
      score_q <= score_d;
      won_q <= won_d;
      lost_q <= lost_d;
      hold_q <= hold_d;
    end
  end
  assign move_ready = state_q == IDLE;
  assign board_out = board_q;
  assign turns = turns_q;
  assign score = score_q;
  assign won = won_q;
  assign lost = lost_q;
endmodule

// File: tb/tb_board_engine_nxn.sv
// tb_board_engine_nxn: directed vector table plus hold, accumulation and async-reset sequences
module tb_board_engine_nxn;
  localparam int N = 4;
  localparam int HOLD_CYC = 1200;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [3:0]  rand_in = 4'd0;
  logic [63:0] board_out;
  logic [13:0] turns;
  logic [19:0] score;
  logic        won, lost;
  logic [63:0] ld_val = '0;
  int          checks = 0;
  int          errors = 0;
  int          lat, m;
`ifdef BOARD_SPAWN_FOUR_EN
  logic [2:0]  rand_hi = 3'd1;
`endif
  typedef struct {
    logic [63:0] init;
    logic [1:0]  dir;
    logic [3:0]  rnd;
    logic [63:0] exp_board;
    logic [13:0] exp_turns;
    logic [19:0] exp_score;
    logic        exp_won;
    logic        exp_lost;
  } vec_t;
  vec_t vecs[9];
  board_engine_nxn dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .rand_in    (rand_in),
`ifdef BOARD_SPAWN_FOUR_EN
    .rand_hi    (rand_hi),
`endif
    .board_out  (board_out),
    .turns      (turns),
    .score      (score),
    .won        (won),
    .lost       (lost)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task do_reset();
    move_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task load(input logic [63:0] b);
    ld_val = b;
    force dut.board_q = ld_val;
    @(posedge clk);
    #1 release dut.board_q;
  endtask
  task run_move(input logic [1:0] d, input logic [3:0] r);
    move_dir = d;
    rand_in = r;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    lat = 1;
    while (!move_ready && lat < N + 3) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  initial begin
    vecs[0] = '{64'h0000_0000_0000_1111, 2'd0, 4'd0,  64'h0000_0000_0000_0122, 14'd1, 20'd8,       1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0112, 2'd1, 4'd0,  64'h0000_0000_0000_2201, 14'd1, 20'd4,       1'b0, 1'b0};
    vecs[2] = '{64'h0004_0003_0002_0001, 2'd0, 4'd5,  64'h0004_0003_0002_0001, 14'd0, 20'd0,       1'b0, 1'b0};
    vecs[3] = '{64'h2100_0000_0000_0003, 2'd1, 4'd14, 64'h2100_0000_0000_3001, 14'd1, 20'd0,       1'b0, 1'b0};
    vecs[4] = '{64'h0020_0020_0020_0000, 2'd2, 4'd0,  64'h0000_0000_0020_0031, 14'd1, 20'd8,       1'b0, 1'b0};
    vecs[5] = '{64'h2000_2000_1000_1000, 2'd3, 4'd3,  64'h3000_2000_0000_1000, 14'd1, 20'd12,      1'b0, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_00AA, 2'd0, 4'd0,  64'h0000_0000_0000_001B, 14'd1, 20'h00800,   1'b1, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_00FF, 2'd0, 4'd0,  64'h0000_0000_0000_001F, 14'd1, 20'h10000,   1'b1, 1'b0};
    vecs[8] = '{64'h3130_3131_1313_3131, 2'd0, 4'd15, 64'h1313_3131_1313_3131, 14'd1, 20'd0,       1'b0, 1'b1};
    do_reset();
    check("reset board", board_out, 64'h0);
    check("reset turns", 64'(turns), 64'h0);
    check("reset score", 64'(score), 64'h0);
    check("reset flags", {62'h0, won, lost}, 64'h0);
    check("reset ready", 64'(move_ready), 64'h1);
    for (int i = 0; i < 9; i++) begin
      do_reset();
      load(vecs[i].init);
      run_move(vecs[i].dir, vecs[i].rnd);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(N + 3));
      check($sformatf("v%0d board", i), board_out, vecs[i].exp_board);
      check($sformatf("v%0d turns", i), 64'(turns), 64'(vecs[i].exp_turns));
      check($sformatf("v%0d score", i), 64'(score), 64'(vecs[i].exp_score));
      check($sformatf("v%0d won", i), 64'(won), 64'(vecs[i].exp_won));
      check($sformatf("v%0d lost", i), 64'(lost), 64'(vecs[i].exp_lost));
      check($sformatf("v%0d ready", i), 64'(move_ready), 64'(!(vecs[i].exp_won || vecs[i].exp_lost)));
    end
    do_reset();
    load(64'h0000_0000_0000_00AA);
    run_move(2'd0, 4'd0);
    check("hold won", 64'(won), 64'h1);
    m = 0;
    while (!move_ready && m < 2000) begin
      @(posedge clk);
      #1 m++;
    end
    check("hold cycles", 64'(m), 64'(HOLD_CYC));
    check("hold board", board_out, 64'h0);
    check("hold turns", 64'(turns), 64'h0);
    check("hold score", 64'(score), 64'h0);
    check("hold flags", {62'h0, won, lost}, 64'h0);
    do_reset();
    load(64'h0000_0000_0000_1111);
    run_move(2'd0, 4'd0);
    move_dir = 2'd0;
    rand_in = 4'd0;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_dir = 2'd1;
    @(posedge clk);
    @(posedge clk);
    #1 move_valid = 1'b0;
    m = 0;
    while (!move_ready && m < 20) begin
      @(posedge clk);
      #1 m++;
    end
    check("acc ready", 64'(move_ready), 64'h1);
    check("acc board", board_out, 64'h0000_0000_0000_0113);
    check("acc turns", 64'(turns), 64'd2);
    check("acc score", 64'(score), 64'd16);
    move_dir = 2'd0;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst board", board_out, 64'h0);
    check("arst turns", 64'(turns), 64'h0);
    check("arst score", 64'(score), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("arst ready", 64'(move_ready), 64'h1);
    load(64'h0000_0000_0000_1111);
    run_move(2'd0, 4'd0);
    check("post latency", 64'(lat), 64'(N + 3));
    check("post board", board_out, 64'h0000_0000_0000_0122);
    check("post turns", 64'(turns), 64'd1);
    check("post score", 64'(score), 64'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_engine_nxn.md
Name: board_engine_nxn

Overview:
Parametrised successor of the 2048 game-logic engine. Supports an NxN board, a configurable tile exponent width, and a valid/ready move interface. Moves are processed one line per clock rather than in one combinational always block. A tile spawns and the turn counter advances only when a move actually changes the board. Adds score tracking, and sits between the button-edge/debounce front end and the board renderer.

Parameters:
N, 4, board side length (2..8); cells = N*N
TILE_W, 4, bits per cell; a cell holds exponent e (value 2^e), 0 = empty
WIN_EXP, 11, exponent that declares a win
TURN_W, 14, turn counter width
SCORE_W, 20, score width
HOLD_CYC, 1200, cycles the won/lost state is held before auto-clear

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
move_valid  in  1  move request
move_dir  in  2  0=left 1=right 2=up 3=down
move_ready  out  1  engine idle and able to accept a move
rand_in  in  $clog2(N*N)  random start cell index for spawn
board_out  out  N*N*TILE_W  cell k=r*N+c (r=0 top, c=0 left) at [k*TILE_W +: TILE_W]
turns  out  TURN_W  count of effective moves
score  out  SCORE_W  sum of 2^e of every tile created by a merge
won  out  1  win flag
lost  out  1  loss flag

Behaviour:
- Reset (async, any state): board, turns, score, won, lost = 0; FSM to IDLE; move_ready=1 after release.
- FSM states: IDLE, SLIDE, SPAWN, CHECK, HOLD.
- IDLE: move_ready=1. On move_valid&&move_ready the engine latches move_dir, clears the changed flag and goes to SLIDE. Requests outside IDLE are ignored (no queue).
- SLIDE: line index i = 0..N-1, one line per cycle. Line i is row i for L/R or column i for U/D, read toward the move direction (reversed for R/D).
  - Compress toward the head; equal adjacent nonzero pairs merge once per move (2048 rules: [1,1,1,1] -> [2,2,0,0]).
  - Merged exponent = e+1, saturating at 2^TILE_W-1.
  - score += 2^(e+1) per merge, saturating at all-ones.
  - changed |= (line differs).
  - After line N-1: go to SPAWN.
- SPAWN, 1 cycle: if changed, search cells rand_in, rand_in+1, ... modulo N*N and write exponent 1 into the first empty cell; turns += 1 (wraps). If not changed, nothing is written. Because the board changed, at least one cell is empty.
- CHECK, 1 cycle:
  - won=1 if any cell >= WIN_EXP.
  - lost=1 if no cell is empty and no horizontally or vertically adjacent pair is equal.
  - Won takes priority; lost is 0 when won=1.
  - Go to HOLD if won||lost, else IDLE.
- Fixed latency: acceptance at cycle 0, move_ready high again at cycle N+3, whether or not the board changed.
- HOLD: counts HOLD_CYC cycles with move_ready=0. Then board, turns, score, won, lost are cleared and the FSM returns to IDLE.
- board_out, turns, score, won, lost are registered. Intermediate SLIDE results are visible on board_out.

Optional Feature:
Macro BOARD_SPAWN_FOUR_EN.
- Defined: adds input rand_hi[2:0]. A spawn writes exponent 2 when rand_hi==0, otherwise exponent 1.
- Undefined: port absent; a spawn always writes exponent 1.

Decomposition:
- Package board_pkg: direction codes (DIR_LEFT..DIR_DOWN), FSM state enum, and a cell-index helper function (r,c)->k.
- Sub-module board_line_slide: combinational N-entry compress/merge.
  - Inputs: N exponents, head first.
  - Outputs: result line, changed bit, score delta.
- The engine handles line gather/scatter, spawn, checks and the FSM.

Test Plan:
- N=4, row0=[1,1,1,1], other cells empty, move left, rand_in=0 -> row0=[2,2,0,0]; spawn at cell 2; turns=1; score=8; move_ready high 7 cycles after acceptance.
- row0=[2,1,1,0], move right -> row0=[0,0,2,2]; score +=4; turns=1.
- Only column 0 occupied with distinct values, move left -> board unchanged, no spawn, turns=0, score unchanged.
- Spawn wrap: cells 14 and 15 occupied, cell 0 empty after the move, rand_in=14 -> cell 0 gets 1.
- Win: row0=[10,10,0,0], move left -> cell0=11, won=1, lost=0. Hold 1200 cycles, then board=0, turns=0, score=0, won=0, move_ready=1.
- Lost: a move leaves a full checkerboard of 1/3 with no equal neighbours -> lost=1, then HOLD.
- Reset: assert rst mid-SLIDE -> all outputs 0 immediately; move_ready=1 after release; the next move behaves normally.
